// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch/decode/control sequencer for the 8-bit two-register CPU (IFD_SINGLE_STEP_EN adds step input and PAUSE state)
module instr_fetch_decode #(
  parameter int PC_W        = 5,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  input  logic            mem_done,
`ifdef IFD_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [2:0]      opcode_out,
  output logic            rs_out,
  output logic            rd_out,
  output logic [7:0]      imm_out,
  output logic            wb_en,
  output logic            halted,
  output logic            fault
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_LW = 3'd3, OP_SW = 3'd5, OP_JMP = 3'd6, OP_HALT = 3'd7;
  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEMWAIT, WB, HALT, FAULT
`ifdef IFD_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;
  state_t state, next_state, ret;
  logic [PC_W-1:0] pc, pc_nx;
  logic [7:0] ir, tcnt, tcnt_nx;
  logic [2:0] op;
  logic mem_op;
  assign op = ir[7:5];
  assign mem_op = op == OP_LW || op == OP_SW;
  assign opcode_out = op;
  assign rs_out = ir[4];
  assign rd_out = ir[3];
  assign imm_out = op == OP_JMP ? {{3{ir[4]}}, ir[4:0]} : {{5{ir[2]}}, ir[2:0]};
  assign imem_addr = pc;
  assign wb_en = state == WB;
  assign halted = state == HALT;
  assign fault = state == FAULT;
`ifdef IFD_SINGLE_STEP_EN
  logic armed;
  assign ret = PAUSE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else armed <= state == PAUSE && step && armed ? 1'b0 : armed | ~step;
`else
  assign ret = FETCH;
`endif
  always_comb begin
    next_state = state;
    pc_nx = pc;
    tcnt_nx = '0;
    case (state)
      FETCH: begin
        next_state = !imem_req ? FETCH : imem_ack ? DECODE : tcnt == 8'(ACK_TIMEOUT - 1) ? FAULT : FETCH;
        tcnt_nx = imem_req && !imem_ack ? tcnt + 8'd1 : '0;
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        next_state = op == OP_HALT ? HALT : mem_op ? MEMWAIT : op == OP_NOP || op == OP_JMP ? ret : WB;
        pc_nx = op == OP_JMP ? pc + PC_W'($signed(imm_out)) : op == OP_HALT || mem_op ? pc : pc + PC_W'(1);
      end
      MEMWAIT: if (mem_done) begin
        next_state = op == OP_LW ? WB : ret;
        pc_nx = pc + PC_W'(1);
      end
      WB: next_state = ret;
`ifdef IFD_SINGLE_STEP_EN
      PAUSE: next_state = step && armed ? FETCH : PAUSE;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc <= PC_W'(RESET_PC);
      ir <= '0;
      tcnt <= '0;
      imem_req <= 1'b0;
    end else begin
      state <= next_state;
      pc <= pc_nx;
      tcnt <= tcnt_nx;
      imem_req <= next_state == FETCH;
      if (state == FETCH && imem_req && imem_ack) ir <= imem_data;
    end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed and randomized checks of instr_fetch_decode against an instruction-level model
module tb_instr_fetch_decode;
  localparam int PC_W = 5;
  localparam int N = 1 << PC_W;
  logic clk = 1'b0, rst_n, imem_ack = 1'b0, mem_done = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic imem_req, rs_out, rd_out, wb_en, halted, fault;
  logic [PC_W-1:0] imem_addr;
  logic [2:0] opcode_out;
  logic [7:0] imm_out;
  logic [7:0] mem [N];
  int total = 0, bad = 0, pc_m = 0;
`ifdef IFD_SINGLE_STEP_EN
  logic step = 1'b0;
  initial forever @(negedge clk) step = ~step;
`endif
  instr_fetch_decode #(.PC_W(PC_W), .RESET_PC(0), .ACK_TIMEOUT(15)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .mem_done(mem_done),
`ifdef IFD_SINGLE_STEP_EN
    .step(step),
`endif
    .opcode_out(opcode_out),
    .rs_out(rs_out),
    .rd_out(rd_out),
    .imm_out(imm_out),
    .wb_en(wb_en),
    .halted(halted),
    .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int sext(input int v, input int bits);
    return v >= (1 << (bits - 1)) ? v - (1 << bits) : v;
  endfunction
  function automatic int next_pc(input int pc, input logic [7:0] ins);
    int op = int'(ins[7:5]);
    int d = op == 6 ? sext(int'(ins[4:0]), 5) : op == 7 ? 0 : 1;
    return ((pc + d) % N + N) % N;
  endfunction
  task automatic fetch_exec(input int dly, input int mdly);
    logic [7:0] ins;
    int op, n, w, gap, want;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imem_req), 1);
    chk("fetch_addr", 32'(imem_addr), pc_m);
    repeat (dly) begin
      @(negedge clk);
      chk("req_hold", 32'({imem_req, imem_addr}), 32'({1'b1, PC_W'(pc_m)}));
    end
    ins = mem[pc_m];
    op = int'(ins[7:5]);
    imem_data = ins;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_data = 8'($urandom);
    chk("req_drop", 32'(imem_req), 0);
    chk("opcode", 32'(opcode_out), op);
    chk("rs", 32'(rs_out), 32'(ins[4]));
    chk("rd", 32'(rd_out), 32'(ins[3]));
    chk("imm", 32'(imm_out), (op == 6 ? sext(int'(ins[4:0]), 5) : sext(int'(ins[2:0]), 3)) & 255);
    w = 0;
    gap = 1;
    n = 0;
    while (!imem_req && !halted && n < 60) begin
      mem_done = mdly < 0 ? ($urandom_range(0, 2) == 0) : (n >= mdly);
      @(negedge clk);
      n++;
      if (wb_en) w++;
      if (!imem_req && !halted) gap++;
    end
    mem_done = 1'b0;
    want = next_pc(pc_m, ins);
    chk("wb_count", w, (op inside {1, 2, 3, 4}) ? 1 : 0);
    if (op == 7) begin
      chk("halted", 32'(halted), 1);
      chk("halt_pc", 32'(imem_addr), pc_m);
    end else
      chk("next_addr", 32'({imem_req, imem_addr}), 32'({1'b1, PC_W'(want)}));
`ifndef IFD_SINGLE_STEP_EN
    if (!(op inside {3, 5}) || mdly >= 2)
      chk("latency", gap, (op inside {1, 2, 4}) ? 3 : op == 3 ? mdly + 2 : op == 5 ? mdly + 1 : 2);
`endif
    pc_m = want;
  endtask
  initial begin
    int reqs;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({imem_req, wb_en, halted, fault, opcode_out, rs_out, rd_out, imm_out, imem_addr}), 0);
    mem[0] = 8'b001_0_1_000;
    mem[1] = 8'b100_1_0_111;
    mem[2] = 8'b110_00001;
    mem[3] = 8'b110_11100;
    mem[31] = 8'b110_11111;
    mem[30] = 8'b110_00010;
    rst_n = 1'b1;
    fetch_exec(2, -1);
    fetch_exec(0, -1);
    fetch_exec(1, -1);
    fetch_exec(0, -1);
    fetch_exec(3, -1);
    fetch_exec(0, -1);
    mem[0] = 8'b011_0_1_000;
    mem[1] = 8'b101_1_0_000;
    fetch_exec(1, 8);
    fetch_exec(0, 3);
    for (int i = 0; i < N; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i][7:5] == 3'd7) mem[i][7:5] = 3'd0;
    end
    for (int k = 0; k < 120; k++) fetch_exec(int'($urandom_range(0, 5)), -1);
    reqs = 0;
    for (int k = 0; k < 60 && !fault; k++) begin
      if (imem_req) reqs++;
      @(negedge clk);
    end
    chk("timeout_cycles", reqs, 15);
    chk("fault_state", 32'({fault, imem_req}), 32'(2'b10));
    repeat (5) @(negedge clk);
    chk("fault_hold", 32'({fault, imem_req}), 32'(2'b10));
    rst_n = 1'b0;
    #1 chk("fault_rst", 32'({fault, imem_req, halted, wb_en}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    reqs = 0;
    while (!imem_req && reqs < 10) begin
      @(negedge clk);
      reqs++;
    end
    chk("refetch_req", 32'(imem_req), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midfetch_rst", 32'({imem_req, wb_en, halted, fault, opcode_out, rs_out, rd_out, imm_out, imem_addr}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_m = 0;
    mem[0] = 8'hE0;
    fetch_exec(1, -1);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    chk("halt_no_req", reqs, 0);
    chk("halt_hold", 32'({halted, wb_en}), 32'(2'b10));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
